lsu_ctrl: RTL and testbench



---
 rtl/lsu_ctrl.sv | 208 ++++++++++++++++++++
 tb/tb_lsu_ctrl.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/lsu_ctrl.sv
// Load/store unit between the execute/memory stage and word-wide data memory.
// Define LSU_MISALIGN_TRAP_EN to trap misaligned half/word accesses.
module lsu_ctrl #(
  parameter int WORD_AW = 6
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_write,
  output logic        mem_read,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_RMW_READ,
    S_STORE,
    S_RESP
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [WORD_AW+1:0] r_addr;
  logic [1:0]         r_size;
  logic               r_signed;
  logic [31:0]        r_wdata;
  logic [31:0]        r_wbuf;
  logic [31:0]        r_rdata;
  logic               r_err;

  logic               w_req_half;
  logic               w_req_word;
  logic               w_misal;
  logic               w_trap;
  logic [1:0]         w_lo;
  logic [WORD_AW+1:0] w_cap_addr;
  logic               w_unused;

  assign w_unused   = ^req_addr[31:WORD_AW+2];
  assign w_req_half = (req_size == 2'b01);
  assign w_req_word = req_size[1];
  assign w_misal    = (w_req_half & req_addr[0]) |
                      (w_req_word & (|req_addr[1:0]));

`ifdef LSU_MISALIGN_TRAP_EN
  assign w_trap = w_misal;
  assign w_lo   = req_addr[1:0];
`else
  assign w_trap = 1'b0;
  // Misaligned low bits are dropped so the access lands on its natural boundary.
  assign w_lo   = w_req_word ? 2'b00 :
                  {req_addr[1], req_addr[0] & ~w_req_half};
`endif

  assign w_cap_addr = {req_addr[WORD_AW+1:2], w_lo};

  logic        w_is_byte;
  logic        w_is_half;
  logic        w_is_word;
  logic [4:0]  w_sh;
  logic [31:0] w_shifted;
  logic [15:0] w_half;
  logic [31:0] w_load;
  logic [31:0] w_mask;
  logic [31:0] w_merge;

  assign w_is_byte = (r_size == 2'b00);
  assign w_is_half = (r_size == 2'b01);
  assign w_is_word = r_size[1];
  assign w_sh      = {r_addr[1:0], 3'b000};
  assign w_shifted = mem_rdata >> w_sh;
  assign w_half    = r_addr[1] ? mem_rdata[31:16] : mem_rdata[15:0];

  always_comb begin
    w_load = mem_rdata;
    w_mask = 32'hFFFF_FFFF;
    unique case (1'b1)
      w_is_byte: begin
        w_load = {{24{r_signed & w_shifted[7]}}, w_shifted[7:0]};
        w_mask = 32'h0000_00FF << w_sh;
      end
      w_is_half: begin
        w_load = {{16{r_signed & w_half[15]}}, w_half};
        w_mask = 32'h0000_FFFF << {r_addr[1], 4'b0000};
      end
      w_is_word: begin
        w_load = mem_rdata;
        w_mask = 32'hFFFF_FFFF;
      end
    endcase
  end

  // Half stores have addr[0]==0 here, so a byte-granular shift also fits them.
  assign w_merge = (mem_rdata & ~w_mask) | ((r_wdata << w_sh) & w_mask);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next    = r_state;
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          if (w_trap) begin
            w_next = S_RESP;
          end else if (!req_write) begin
            w_next = S_LOAD;
          end else if (w_req_word) begin
            w_next = S_STORE;
          end else begin
            w_next = S_RMW_READ;
          end
        end
      end
      S_LOAD: begin
        mem_read = !rst;
        w_next   = S_RESP;
      end
      S_RMW_READ: begin
        mem_read = !rst;
        w_next   = S_STORE;
      end
      S_STORE: begin
        mem_write = !rst;
        w_next    = S_RESP;
      end
      S_RESP: begin
        rsp_valid = 1'b1;
        w_next    = S_IDLE;
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_addr   <= '0;
      r_size   <= 2'b00;
      r_signed <= 1'b0;
      r_wdata  <= '0;
      r_wbuf   <= '0;
      r_rdata  <= '0;
      r_err    <= 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (req_valid) begin
            r_addr   <= w_cap_addr;
            r_size   <= req_size;
            r_signed <= req_signed;
            r_wdata  <= req_wdata;
            if (req_write && w_req_word) begin
              r_wbuf <= req_wdata;
            end
            if (w_trap) begin
              r_rdata <= '0;
              r_err   <= 1'b1;
            end
          end
        end
        S_LOAD: begin
          r_rdata <= w_load;
          r_err   <= 1'b0;
        end
        S_RMW_READ: begin
          r_wbuf <= w_merge;
        end
        S_STORE: begin
          r_rdata <= '0;
          r_err   <= 1'b0;
        end
        default: begin
        end
      endcase
    end
  end

  assign mem_addr  = {{(32-WORD_AW){1'b0}}, r_addr[WORD_AW+1:2]};
  assign mem_wdata = r_wbuf;
  assign rsp_rdata = r_rdata;
  assign rsp_err   = r_err;

endmodule

// File: tb/tb_lsu_ctrl.sv
// Scoreboard bench for lsu_ctrl with a behavioural word memory.
// Expectations follow LSU_MISALIGN_TRAP_EN when it is defined.
module tb_lsu_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [1:0]  req_size;
  logic        req_signed;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_write;
  logic        mem_read;
  logic [31:0] mem_rdata;

  lsu_ctrl #(.WORD_AW(6)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_write(req_write), .req_size(req_size),
    .req_signed(req_signed), .req_addr(req_addr),
    .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_write(mem_write), .mem_read(mem_read),
    .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  logic [31:0] mem [64];
  assign mem_rdata = mem[mem_addr[5:0]];
  always @(posedge clk) begin
    if (mem_write) mem[mem_addr[5:0]] <= mem_wdata;
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    string       nm;
    logic [31:0] rdata;
    logic        err;
    int          acc;
    int          lat;
  } exp_t;

  exp_t q[$];
  int errors = 0;
  int checks = 0;
  int accepts = 0;
  int reqs = 0;
  int both = 0;
  int act = 0;

  function automatic void chk(string nm, logic [31:0] a, logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, a, e);
    end
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      if (req_valid && req_ready) accepts++;
      if (mem_read && mem_write) both++;
      if (mem_read || mem_write) act++;
      if (rsp_valid) begin
        if (q.size() == 0) begin
          chk("unexpected_rsp", 32'd1, 32'd0);
        end else begin
          e = q.pop_front();
          chk({e.nm, "_rdata"}, rsp_rdata, e.rdata);
          chk({e.nm, "_err"}, {31'd0, rsp_err}, {31'd0, e.err});
          chk({e.nm, "_lat"}, 32'(cyc - e.acc), 32'(e.lat));
        end
      end
    end
  end

  task automatic issue(input string nm, input logic w,
                       input logic [1:0] sz, input logic sg,
                       input logic [31:0] a, input logic [31:0] wd,
                       input logic [31:0] er, input logic ee,
                       input int lat, input logic [31:0] ema,
                       input logic hold);
    exp_t e;
    int n;
    req_write  = w;
    req_size   = sz;
    req_signed = sg;
    req_addr   = a;
    req_wdata  = wd;
    req_valid  = 1'b1;
    reqs++;
    n = 0;
    while (!req_ready && n < 50) begin
      @(posedge clk); #1; n++;
    end
    if (!req_ready) chk({nm, "_accept_timeout"}, 32'd1, 32'd0);
    e.nm = nm; e.rdata = er; e.err = ee; e.acc = cyc; e.lat = lat;
    q.push_back(e);
    @(posedge clk); #1;
    chk({nm, "_mem_addr"}, mem_addr, ema);
    if (hold) begin
      n = 0;
      while (!rsp_valid && n < 10) begin
        @(posedge clk); #1; n++;
      end
    end
    req_valid = 1'b0;
    n = 0;
    while (q.size() != 0 && n < 20) begin
      @(posedge clk); #1; n++;
    end
    if (q.size() != 0) begin
      chk({nm, "_rsp_timeout"}, 32'd1, 32'd0);
      q.delete();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    int a0;
    for (int i = 0; i < 64; i++) mem[i] = 32'h0;
    rst = 1'b1;
    req_valid = 1'b0; req_write = 1'b0; req_size = 2'b00;
    req_signed = 1'b0; req_addr = '0; req_wdata = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    chk("rst_ready", {31'd0, req_ready}, 32'd1);
    chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("rst_rdata", rsp_rdata, 32'd0);
    chk("rst_err", {31'd0, rsp_err}, 32'd0);
    chk("rst_mem_rw", {30'd0, mem_read, mem_write}, 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_mem_wdata", mem_wdata, 32'd0);

    issue("sw10", 1, 2'b10, 0, 32'h10, 32'hDEADBEEF, 0, 0, 2, 4, 0);
    issue("lw10", 0, 2'b10, 0, 32'h10, 0, 32'hDEADBEEF, 0, 2, 4, 0);

    issue("sw10b", 1, 2'b10, 0, 32'h10, 32'h11223344, 0, 0, 2, 4, 0);
    issue("sb13", 1, 2'b00, 0, 32'h13, 32'h000000AA, 0, 0, 3, 4, 0);
    issue("lw10c", 0, 2'b10, 0, 32'h10, 0, 32'hAA223344, 0, 2, 4, 0);
    issue("lb13", 0, 2'b00, 1, 32'h13, 0, 32'hFFFFFFAA, 0, 2, 4, 0);
    issue("lbu13", 0, 2'b00, 0, 32'h13, 0, 32'h000000AA, 0, 2, 4, 0);

    issue("sw20", 1, 2'b10, 0, 32'h20, 32'h0, 0, 0, 2, 8, 0);
    issue("sh22", 1, 2'b01, 0, 32'h22, 32'h00008001, 0, 0, 3, 8, 0);
    issue("lw20", 0, 2'b10, 0, 32'h20, 0, 32'h80010000, 0, 2, 8, 0);
    issue("lh22", 0, 2'b01, 1, 32'h22, 0, 32'hFFFF8001, 0, 2, 8, 0);
    issue("lhu20", 0, 2'b01, 0, 32'h20, 0, 32'h00000000, 0, 2, 8, 0);
    issue("sw11_3", 1, 2'b11, 0, 32'h2C, 32'hCAFE0001, 0, 0, 2, 11, 0);
    issue("lw2c", 0, 2'b11, 0, 32'h2C, 0, 32'hCAFE0001, 0, 2, 11, 0);

    a0 = act;
`ifdef LSU_MISALIGN_TRAP_EN
    issue("lw11", 0, 2'b10, 0, 32'h11, 0, 32'h0, 1, 1, 4, 0);
    issue("lhu13", 0, 2'b01, 0, 32'h13, 0, 32'h0, 1, 1, 4, 0);
    chk("trap_no_mem", 32'(act - a0), 32'd0);
`else
    issue("lw11", 0, 2'b10, 0, 32'h11, 0, 32'hAA223344, 0, 2, 4, 0);
    issue("lhu13", 0, 2'b01, 0, 32'h13, 0, 32'h0000AA22, 0, 2, 4, 0);
    chk("mis_mem_used", {31'd0, (act - a0) == 2}, 32'd1);
`endif

    issue("sw08", 1, 2'b10, 0, 32'h08, 32'h12345678, 0, 0, 2, 2, 0);
    req_write = 1'b1; req_size = 2'b10; req_signed = 1'b0;
    req_addr = 32'h08; req_wdata = 32'h00000055; req_valid = 1'b1;
    reqs++;
    chk("rstst_ready", {31'd0, req_ready}, 32'd1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    rst = 1'b1;
    #1;
    chk("rstst_mem_write", {31'd0, mem_write}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    chk("rstst_ready_after", {31'd0, req_ready}, 32'd1);
    chk("rstst_no_rsp", {31'd0, rsp_valid}, 32'd0);
    repeat (4) @(posedge clk);
    #1;
    chk("rstst_word", mem[2], 32'h12345678);
    issue("lw08", 0, 2'b10, 0, 32'h08, 0, 32'h12345678, 0, 2, 2, 0);

    issue("sw100", 1, 2'b10, 0, 32'h100, 32'h7, 0, 0, 2, 0, 0);
    chk("wrap_mem0", mem[0], 32'h7);
    issue("lw0", 0, 2'b10, 0, 32'h0, 0, 32'h7, 0, 2, 0, 0);

    issue("lb10_hold", 0, 2'b00, 1, 32'h10, 0, 32'h00000044, 0, 2, 4, 1);
    issue("sb11_hold", 1, 2'b00, 0, 32'h11, 32'h80, 0, 0, 3, 4, 1);
    issue("lb11", 0, 2'b00, 1, 32'h11, 0, 32'hFFFFFF80, 0, 2, 4, 0);

    repeat (3) @(posedge clk);
    #1;
    chk("accept_count", 32'(accepts), 32'(reqs));
    chk("rw_exclusive", 32'(both), 32'd0);
    chk("queue_empty", 32'(q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
